// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// dm_pkg : shared state type, pattern codes and pattern ROM for dm_scan_ctrl
// Rev 1.0
// ============================================================================
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Same encoding the game logic uses for its compare result
  localparam logic [1:0] PAT_MATCH  = 2'b00;
  localparam logic [1:0] PAT_DEFEAT = 2'b01;
  localparam logic [1:0] PAT_DOWN   = 2'b10;
  localparam logic [1:0] PAT_UP     = 2'b11;

  // [code][row], bit 7 = column 7, active-high pixels
  localparam logic [0:3][0:7][7:0] PATTERN_ROM = {
    8'h3C, 8'h42, 8'h81, 8'h81, 8'h81, 8'h81, 8'h42, 8'h3C,
    8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
    8'h18, 8'h18, 8'h18, 8'h18, 8'hFF, 8'h7E, 8'h3C, 8'h18,
    8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h18, 8'h18, 8'h18, 8'h18
  };

endpackage
`default_nettype wire

// File: rtl/dm_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// dm_scan_ctrl_if : control inputs and matrix pin outputs of dm_scan_ctrl
// Rev 1.0
// ============================================================================
interface dm_scan_ctrl_if;

  logic [1:0] i_Pattern;
  logic       i_fLoad;
  logic       i_fClear;
  logic       i_Blink;
  logic       o_Busy;
  logic [7:0] o_DM_Col;
  logic [7:0] o_DM_Row;

  modport master (
    output i_Pattern, i_fLoad, i_fClear, i_Blink,
    input  o_Busy, o_DM_Col, o_DM_Row
  );

  modport slave (
    input  i_Pattern, i_fLoad, i_fClear, i_Blink,
    output o_Busy, o_DM_Col, o_DM_Row
  );

endinterface
`default_nettype wire

// File: rtl/dm_pattern_rom.sv
`default_nettype none
// ============================================================================
// dm_pattern_rom : combinational lookup of one 8-pixel row of a pattern
// Rev 1.0
// ============================================================================
module dm_pattern_rom
  import dm_pkg::*;
(
  input  wire logic [1:0] code,
  input  wire logic [2:0] row,
  output logic      [7:0] data
);

  assign data = PATTERN_ROM[code][row];

endmodule
`default_nettype wire

// File: rtl/dm_scan_ctrl.sv
`default_nettype none
// ============================================================================
// dm_scan_ctrl : loads a ROM pattern into a frame buffer and row-scans the 8x8
//                active-low dot matrix with optional blinking
// Rev 1.0
// ============================================================================
module dm_scan_ctrl
  import dm_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  wire logic    i_Clk,
  input  wire logic    i_Rst,
  dm_scan_ctrl_if.slave dm
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [1:0]       r_code;
  logic [2:0]       r_load_idx;
  logic [7:0]       r_buf [8];
  logic [2:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [FRM_W-1:0] r_frame;
  logic             r_blank;
  logic             r_busy;
  logic [7:0]       r_col;
  logic [7:0]       r_row_sel;
  logic [7:0]       w_rom_data;
  logic             w_enter_load;
  logic             w_enter_scan;

  dm_pattern_rom u_rom (
    .code (r_code),
    .row  (r_load_idx),
    .data (w_rom_data)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (dm.i_fClear) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (dm.i_fLoad) w_state_nx = ST_LOAD;
        ST_LOAD: if (r_load_idx == 3'd7) w_state_nx = ST_SCAN;
        ST_SCAN: if (dm.i_fLoad) w_state_nx = ST_LOAD;
        default: w_state_nx = ST_IDLE;
      endcase
    end
    w_enter_load = (w_state_nx == ST_LOAD) && (r_state != ST_LOAD);
    w_enter_scan = (w_state_nx == ST_SCAN) && (r_state == ST_LOAD);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_code     <= PAT_MATCH;
      r_load_idx <= 3'd0;
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
      r_row      <= 3'd0;
      r_div      <= '0;
      r_frame    <= '0;
      r_blank    <= 1'b0;
      r_busy     <= 1'b0;
      r_col      <= 8'hFF;
      r_row_sel  <= 8'hFF;
    end else begin
      if (w_enter_load) begin
        r_code     <= dm.i_Pattern;
        r_load_idx <= 3'd0;
      end

      if (r_state == ST_LOAD) begin
        r_buf[r_load_idx] <= w_rom_data;
        if (r_load_idx != 3'd7) r_load_idx <= r_load_idx + 3'd1;
      end

      if (w_enter_scan) begin
        r_row   <= 3'd0;
        r_div   <= '0;
        r_frame <= '0;
        r_blank <= 1'b0;
      end else if (r_state == ST_SCAN) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          r_row <= (r_row == 3'd7) ? 3'd0 : r_row + 3'd1;
          if (r_row == 3'd7) begin
            r_frame <= (r_frame == FRM_LAST) ? '0 : r_frame + 1'b1;
            if (r_frame == FRM_LAST) r_blank <= ~r_blank;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      // Without blinking the phase is held at "visible" so re-enabling starts lit
      if (!dm.i_Blink) r_blank <= 1'b0;

      r_busy <= (r_state == ST_LOAD);
      if ((r_state == ST_SCAN) && !(dm.i_Blink && r_blank)) begin
        r_row_sel <= ~(8'd1 << r_row);
        r_col     <= ~r_buf[r_row];
      end else begin
        r_row_sel <= 8'hFF;
        r_col     <= 8'hFF;
      end
    end
  end

  assign dm.o_Busy   = r_busy;
  assign dm.o_DM_Col = r_col;
  assign dm.o_DM_Row = r_row_sel;

endmodule
`default_nettype wire

// File: tb/tb_dm_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dm_scan_ctrl : directed scoreboard bench for dm_scan_ctrl
// Rev 1.0
// ============================================================================
module tb_dm_scan_ctrl;
  import dm_pkg::*;

  localparam int CLK_DIV      = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 8 * CLK_DIV;

  typedef struct {
    int         at;
    logic       busy;
    logic [7:0] col;
    logic [7:0] row;
    string      tag;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb [$];

  // Hand-computed active-low column values, [code][row]
  logic [7:0] col_tab [0:3][0:7] = '{
    '{8'hC3, 8'hBD, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'hBD, 8'hC3},
    '{8'h7E, 8'hBD, 8'hDB, 8'hE7, 8'hE7, 8'hDB, 8'hBD, 8'h7E},
    '{8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'h00, 8'h81, 8'hC3, 8'hE7},
    '{8'hE7, 8'hC3, 8'h81, 8'h00, 8'hE7, 8'hE7, 8'hE7, 8'hE7}
  };
  logic [7:0] row_tab [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  dm_scan_ctrl_if dm_if ();

  dm_scan_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .dm    (dm_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(int at, logic b, logic [7:0] c, logic [7:0] r, string tag);
    exp_t e;
    e.at = at; e.busy = b; e.col = c; e.row = r; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_blank(int from, int to, logic b, string tag);
    for (int t = from; t <= to; t++) expect_at(t, b, 8'hFF, 8'hFF, tag);
  endtask

  task automatic expect_scan(int base, int from, int to, int pat, string tag);
    for (int t = from; t <= to; t++) begin
      int r;
      r = ((t - base) % FRAME) / CLK_DIV;
      expect_at(t, 1'b0, col_tab[pat][r], row_tab[r], tag);
    end
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.at != cyc || dm_if.o_Busy !== e.busy ||
          dm_if.o_DM_Col !== e.col || dm_if.o_DM_Row !== e.row) begin
        n_fail++;
        $display("FAIL %s cyc=%0d: busy/col/row got %b/%h/%h expected %b/%h/%h (due cyc %0d)",
                 e.tag, cyc, dm_if.o_Busy, dm_if.o_DM_Col, dm_if.o_DM_Row,
                 e.busy, e.col, e.row, e.at);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int b;
    dm_if.i_Pattern = PAT_MATCH;
    dm_if.i_fLoad   = 1'b0;
    dm_if.i_fClear  = 1'b0;
    dm_if.i_Blink   = 1'b0;

    // Reset held, then idle with no load
    expect_blank(1, 3, 1'b0, "reset");
    expect_blank(4, 8, 1'b0, "idle");
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);

    // UP load: busy 8 cycles then one full frame plus row 0 again
    n = cyc;
    dm_if.i_Pattern = PAT_UP;
    dm_if.i_fLoad   = 1'b1;
    expect_blank(n + 1, n + 1, 1'b0, "up_pre");
    expect_blank(n + 2, n + 9, 1'b1, "up_busy");
    expect_scan(n + 10, n + 10, n + 10 + FRAME + CLK_DIV - 1, 3, "up_scan");
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(n + 10 + FRAME + CLK_DIV);

    // MATCH with blink: 2 frames lit, 2 frames blank, repeat; then drop blink while blank
    n = cyc;
    dm_if.i_Pattern = PAT_MATCH;
    dm_if.i_fLoad   = 1'b1;
    dm_if.i_Blink   = 1'b1;
    b = n + 10;
    expect_blank(n + 2, n + 9, 1'b1, "match_busy");
    expect_scan(b, b, b + 63, 0, "blink_on");
    expect_blank(b + 64, b + 127, 1'b0, "blink_off");
    expect_scan(b, b + 128, b + 135, 0, "blink_rep");
    expect_blank(b + 199, b + 200, 1'b0, "blink_off2");
    expect_scan(b, b + 201, b + 205, 0, "blink_drop");
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(b + 200);
    dm_if.i_Blink = 1'b0;
    wait_cyc(b + 206);

    // Reload DEFEAT during row 3; a second load request during LOAD is ignored
    while (((cyc + 1 - b) % FRAME) != 13) @(negedge clk);
    n = cyc;
    dm_if.i_Pattern = PAT_DEFEAT;
    dm_if.i_fLoad   = 1'b1;
    expect_scan(b, n + 1, n + 1, 0, "pre_reload");
    expect_blank(n + 2, n + 9, 1'b1, "reload_busy");
    expect_scan(n + 10, n + 10, n + 10 + FRAME - 1, 1, "defeat");
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(n + 3);
    dm_if.i_Pattern = PAT_DOWN;
    dm_if.i_fLoad   = 1'b1;
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(n + 10 + FRAME);

    // Clear wins over a simultaneous load
    n = cyc;
    dm_if.i_Pattern = PAT_UP;
    dm_if.i_fLoad   = 1'b1;
    dm_if.i_fClear  = 1'b1;
    expect_blank(n + 2, n + 12, 1'b0, "clear");
    @(negedge clk);
    dm_if.i_fLoad  = 1'b0;
    dm_if.i_fClear = 1'b0;
    wait_cyc(n + 13);

    // Async reset between edges during LOAD
    n = cyc;
    dm_if.i_Pattern = PAT_DOWN;
    dm_if.i_fLoad   = 1'b1;
    expect_blank(n + 2, n + 4, 1'b1, "load_pre_rst");
    expect_blank(n + 5, n + 7, 1'b0, "async_rst");
    expect_blank(n + 8, n + 10, 1'b0, "post_rst");
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(n + 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    wait_cyc(n + 7);
    rst_n = 1'b1;
    wait_cyc(n + 10);

    // DOWN load after reset: row 4 column data is 00
    n = cyc;
    dm_if.i_Pattern = PAT_DOWN;
    dm_if.i_fLoad   = 1'b1;
    expect_blank(n + 1, n + 1, 1'b0, "down_pre");
    expect_blank(n + 2, n + 9, 1'b1, "down_busy");
    expect_scan(n + 10, n + 10, n + 10 + FRAME - 1, 2, "down");
    @(negedge clk);
    dm_if.i_fLoad = 1'b0;
    wait_cyc(n + 10 + FRAME + 2);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending got %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
